// File: rtl/aes_tb_pkg.sv
// Shared widths and FSM encoding for the result capture memory.
// Byte lanes are numbered MSB-first so lane 0 lands in bits [127:120].
package aes_tb_pkg;

    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_W         = 128;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Top bit of byte lane idx inside a word.
    function automatic int byte_msb(input int idx);
        return WORD_W - 1 - BYTE_W * idx;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into a 128-bit word, MSB-first, and tracks the
// next free lane. The count wraps to 0 after the 16th byte.
module byte_assembler
    import aes_tb_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_byte_cnt,
    output logic              o_last_byte
);

    logic [CNT_W-1:0]          r_byte_cnt;
    logic [BYTES_PER_WORD-1:0] w_lane_sel;

    // One register per lane; only the lane addressed by the count loads.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            localparam int LANE_MSB = byte_msb(gi);
            logic [BYTE_W-1:0] r_lane;

            assign w_lane_sel[gi] = i_load && (r_byte_cnt == CNT_W'(gi));

            always_ff @(posedge clk) begin
                if (i_rst || i_clear) begin
                    r_lane <= '0;
                end else if (w_lane_sel[gi]) begin
                    r_lane <= i_byte;
                end
            end

            assign o_word[LANE_MSB -: BYTE_W] = r_lane;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign o_byte_cnt  = r_byte_cnt;
    assign o_last_byte = (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/result_capture_ram.sv
// Captures 16-byte groups into a 128-bit result memory at an incrementing
// pointer; stops accepting once DEPTH words are stored (no wrap).
module result_capture_ram
    import aes_tb_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              word_done,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [ADDR_W:0]   word_cnt,
    output logic              full,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W:0]     r_word_cnt;
    logic [ADDR_W:0]     w_word_cnt_inc;
    logic                w_load;
    logic                w_last_byte;
    logic                w_mem_we;
    logic [WORD_W-1:0]   w_word;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    assign in_ready  = (r_state == COLLECT);
    assign word_done = (r_state == COMMIT);
    assign full      = (r_state == FULL);
    assign word_cnt  = r_word_cnt;
    assign w_load    = in_valid && in_ready;

    byte_assembler u_assembler (
        .clk         (clk),
        .i_rst       (rst),
        .i_clear     (clear),
        .i_load      (w_load),
        .i_byte      (in_byte),
        .o_word      (w_word),
        .o_byte_cnt  (byte_cnt),
        .o_last_byte (w_last_byte)
    );

    assign w_word_cnt_inc = r_word_cnt + (ADDR_W + 1)'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (w_load && w_last_byte) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next = (w_word_cnt_inc == DEPTH_CNT) ? FULL : COLLECT;
            end
            FULL: begin
                w_state_next = FULL;
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state    <= COLLECT;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == COMMIT) begin
                r_word_cnt <= w_word_cnt_inc;
            end
        end
    end

    // A reset or clear arriving in the COMMIT cycle aborts the write.
    assign w_mem_we = (r_state == COMMIT) && !rst && !clear;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_word_cnt[ADDR_W-1:0]] <= w_word;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: tb/tb_result_capture_ram.sv
// Directed and scoreboard bench for result_capture_ram (DEPTH=32 instance).
module tb_result_capture_ram;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              word_done;
    logic [3:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic              full;
    logic [ADDR_W-1:0] rd_addr;
    logic [127:0]      rd_data;

    result_capture_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_done (word_done),
        .byte_cnt  (byte_cnt),
        .word_cnt  (word_cnt),
        .full      (full),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (word_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [127:0]      word;
        bit                gapped;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] exp_mem [DEPTH];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Holds the byte with in_valid until the DUT is ready, then transfers it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        if (guard >= 40) check("ready_timeout", 128'(in_ready), 128'(1));
        step();
    endtask

    task automatic send_word(input logic [127:0] w, input bit gapped);
        for (int i = 0; i < 16; i++) begin
            send_byte(w[127-8*i -: 8]);
            if (gapped) begin
                in_valid = 1'b0;
                step();
            end
        end
        $display("tx word %h gapped=%0d", w, gapped);
    endtask

    task automatic finish_commit();
        in_valid = 1'b0;
        step();
    endtask

    task automatic read_check(input string name, input int addr, input logic [127:0] exp);
        rd_addr = ADDR_W'(addr);
        #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        logic [127:0] w_a;
        int base;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_byte = '0; rd_addr = '0;
        step();
        step();
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_word_done", 128'(word_done), 128'(0));
        check("rst_full",      128'(full),      128'(0));
        check("rst_byte_cnt",  128'(byte_cnt),  128'(0));
        check("rst_word_cnt",  128'(word_cnt),  128'(0));
        rst = 1'b0;
        step();
        check("ready_after_rst", 128'(in_ready), 128'(1));

        // Continuous 0x00..0x0F: ready for 16 cycles, then one COMMIT cycle.
        for (int i = 0; i < 16; i++) begin
            in_byte  = 8'(i);
            in_valid = 1'b1;
            check("t1_ready",    128'(in_ready), 128'(1));
            check("t1_byte_cnt", 128'(byte_cnt), 128'(i));
            step();
        end
        in_valid = 1'b0;
        check("t1_commit_ready", 128'(in_ready),  128'(0));
        check("t1_commit_done",  128'(word_done), 128'(1));
        check("t1_commit_wcnt",  128'(word_cnt),  128'(0));
        step();
        check("t1_done_low",  128'(word_done), 128'(0));
        check("t1_word_cnt",  128'(word_cnt),  128'(1));
        check("t1_ready_back", 128'(in_ready), 128'(1));
        read_check("t1_mem0", 0, 128'h000102030405060708090A0B0C0D0E0F);
        $display("tx word 000102030405060708090a0b0c0d0e0f gapped=0");

        // Table: mixed gapped/continuous words, valid held across COMMIT.
        vecs[0] = '{128'hFFEEDDCCBBAA99887766554433221100, 1'b1, 5'd1};
        vecs[1] = '{128'hDEADBEEFCAFEF00D0123456789ABCDEF, 1'b0, 5'd2};
        vecs[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 5'd3};
        for (int v = 0; v < 3; v++) send_word(vecs[v].word, vecs[v].gapped);
        finish_commit();
        for (int v = 0; v < 3; v++) read_check("tbl_mem", int'(vecs[v].addr), vecs[v].word);
        check("tbl_word_cnt", 128'(word_cnt), 128'(4));

        // Clear mid-word discards the partial bytes, keeps memory.
        for (int i = 0; i < 7; i++) send_byte(8'hAA);
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_byte_cnt", 128'(byte_cnt), 128'(0));
        check("clr_word_cnt", 128'(word_cnt), 128'(0));
        check("clr_ready",    128'(in_ready), 128'(1));
        send_word(128'h101112131415161718191A1B1C1D1E1F, 1'b0);
        finish_commit();
        read_check("clr_mem0", 0, 128'h101112131415161718191A1B1C1D1E1F);
        check("clr_word_cnt1", 128'(word_cnt), 128'(1));
        read_check("clr_mem1_kept", 1, vecs[0].word);

        // Clear in the COMMIT cycle aborts the write to mem[1].
        send_word({16{8'h66}}, 1'b0);
        check("clrc_done", 128'(word_done), 128'(1));
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        read_check("clrc_mem1", 1, vecs[0].word);
        check("clrc_word_cnt", 128'(word_cnt),  128'(0));
        check("clrc_done_low", 128'(word_done), 128'(0));

        // Reset in the COMMIT cycle of word 2 aborts the write to mem[1].
        w_a = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        send_word(w_a, 1'b0);
        finish_commit();
        send_word({16{8'h55}}, 1'b0);
        check("rstc_done", 128'(word_done), 128'(1));
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        read_check("rstc_mem1", 1, vecs[0].word);
        read_check("rstc_mem0", 0, w_a);
        check("rstc_word_cnt", 128'(word_cnt), 128'(0));
        check("rstc_ready",    128'(in_ready), 128'(1));

        // Random fill of all 32 words, then overflow attempt.
        step();
        base = done_cnt;
        for (int w = 0; w < DEPTH; w++) begin
            exp_mem[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
            send_word(exp_mem[w], bit'($urandom_range(0, 1)));
        end
        finish_commit();
        check("full_flag",     128'(full),            128'(1));
        check("full_ready",    128'(in_ready),        128'(0));
        check("full_word_cnt", 128'(word_cnt),        128'(DEPTH));
        check("done_pulses",   128'(done_cnt - base), 128'(DEPTH));
        for (int i = 0; i < 20; i++) begin
            in_byte  = 8'hEE;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("ovf_word_cnt", 128'(word_cnt), 128'(DEPTH));
        check("ovf_full",     128'(full),     128'(1));
        check("ovf_byte_cnt", 128'(byte_cnt), 128'(0));
        check("ovf_done",     128'(done_cnt - base), 128'(DEPTH));
        for (int w = 0; w < DEPTH; w++) read_check("rand_mem", w, exp_mem[w]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
